// File: rtl/vec_exec_pkg.sv
// Shared types and constants for the SIMD execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_exec_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int CNT_W  = $clog2(LANE_W);

    // Positions inside the {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_MUL = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MOV = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU: ADD/SUB/AND/ORR/SHL/SHR/MOV with lane carry and overflow.
// Latency: purely combinational.
// Backpressure: none; MUL is not handled here and yields zero.
module vec_lane_alu
    import vec_exec_pkg::*;
#(
    parameter int W = LANE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] res,
    output logic         carry,
    output logic         ovf
);

    logic [W:0] sum;
    logic [W:0] diff;

    // diff[W] is the no-borrow bit: set when a >= b
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    // Per-op result select; carry/overflow only meaningful for ADD/SUB
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                res   = sum[W-1:0];
                carry = sum[W];
                ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res   = diff[W-1:0];
                carry = diff[W];
                ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  res = a & b;
            OP_ORR:  res = a | b;
            OP_SHL:  res = a << b[2:0];
            OP_SHR:  res = a >> b[2:0];
            OP_MOV:  res = b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_stage.sv
// Execute stage: lane-wise SIMD ALU, condition and flag logic, iterative lane MUL, E/M register.
// Latency: single-cycle ops reach E/M after 1 edge; MUL occupies E for LANE_W+1 cycles.
// Backpressure: stall_o holds upstream while MUL iterates; clr flushes E/M and drops a running MUL.
module vec_exec_stage
    import vec_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [DATA_W-1:0] rdo1,
    input  logic [DATA_W-1:0] rdo2,
    input  logic [DATA_W-1:0] exto,
    input  logic [2:0]        ao3,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              PCSrcE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [1:0]        FlagWriteE,
    input  logic              CondE,
    input  logic [3:0]        FlagsE,
    output logic              stall_o,
    output logic              BranchTakenE,
    output logic [3:0]        FlagsNextE,
    output logic              FlagUpdE,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [2:0]        WA3M,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANE_W - 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_a, mul_b, acc, acc_next;
    logic [DATA_W-1:0] src_b, alu_res, result_e;
    logic [LANES-1:0]  lane_c, lane_v;
    logic              cond_ok, is_mul, is_arith, in_mul, mul_last, em_load;
    logic [3:0]        flags_calc;

    assign src_b    = ALUSrcE ? exto : rdo2;
    assign cond_ok  = ~CondE | FlagsE[FLAG_Z];
    assign is_mul   = (ALUControlE == OP_MUL);
    assign is_arith = (ALUControlE == OP_ADD) || (ALUControlE == OP_SUB);
    assign in_mul   = (state == ST_MUL);
    assign mul_last = in_mul && (cnt == CNT_LAST);
    // A result retires on a single-cycle op in IDLE or on the final MUL step
    assign em_load  = in_mul ? mul_last : ~is_mul;
    // During MUL the visible result is the product including this cycle's step
    assign result_e = in_mul ? acc_next : alu_res;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] la, lb;

        vec_lane_alu #(.W(LANE_W)) u_alu (
            .a     (rdo1[g*LANE_W +: LANE_W]),
            .b     (src_b[g*LANE_W +: LANE_W]),
            .op    (ALUControlE),
            .res   (alu_res[g*LANE_W +: LANE_W]),
            .carry (lane_c[g]),
            .ovf   (lane_v[g])
        );

        // Shift-add step on bit cnt of the lane multiplier; only low LANE_W product bits kept
        assign la = mul_a[g*LANE_W +: LANE_W];
        assign lb = mul_b[g*LANE_W +: LANE_W];
        assign acc_next[g*LANE_W +: LANE_W] = acc[g*LANE_W +: LANE_W] + (lb[cnt] ? (la << cnt) : '0);
    end

    // Next flag value: N/Z from result, C/V from lanes on ADD/SUB, unwritten bits pass through
    always_comb begin
        flags_calc         = FlagsE;
        flags_calc[FLAG_N] = result_e[DATA_W-1];
        flags_calc[FLAG_Z] = (result_e == '0);
        if (!in_mul && is_arith) begin
            flags_calc[FLAG_C] = |lane_c;
            flags_calc[FLAG_V] = |lane_v;
        end
        FlagsNextE = FlagsE;
        if (FlagWriteE[1]) begin
            FlagsNextE[FLAG_N] = flags_calc[FLAG_N];
            FlagsNextE[FLAG_Z] = flags_calc[FLAG_Z];
        end
        if (FlagWriteE[0]) begin
            FlagsNextE[FLAG_C] = flags_calc[FLAG_C];
            FlagsNextE[FLAG_V] = flags_calc[FLAG_V];
        end
    end

    // Stall while a MUL is starting or iterating; reset and flush always release it
    always_comb begin
        stall_o = 1'b0;
        if (!reset || clr) begin
            stall_o = 1'b0;
        end else if (in_mul) begin
            stall_o = (cnt != CNT_LAST);
        end else begin
            stall_o = is_mul & cond_ok;
        end
    end

    assign FlagUpdE     = cond_ok & (|FlagWriteE) & ~stall_o;
    assign BranchTakenE = (BranchE | PCSrcE) & cond_ok & ~in_mul;

    // MUL sequencer: latch operands on entry, one shift-add per edge, exit after the last step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mul && cond_ok) begin
                        state <= ST_MUL;
                        cnt   <= '0;
                        acc   <= '0;
                        mul_a <= rdo1;
                        mul_b <= src_b;
                    end
                end
                ST_MUL: begin
                    acc <= acc_next;
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // E/M boundary register: bubble on flush or when nothing retires this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else if (clr || !em_load) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else begin
            ALUResultM <= result_e;
            WriteDataM <= rdo2;
            WA3M       <= ao3;
            RegWriteM  <= RegWriteE & cond_ok;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE & cond_ok;
        end
    end

endmodule

// File: tb/tb_vec_exec_stage.sv
// Bench for vec_exec_stage: lane-arithmetic model plus per-cycle compare at the falling edge.
// Latency: n/a.
// Backpressure: n/a.
module tb_vec_exec_stage;

    logic        clk = 1'b0;
    logic        reset, clr;
    logic [31:0] rdo1, rdo2, exto;
    logic [2:0]  ao3;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, PCSrcE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  FlagWriteE;
    logic        CondE;
    logic [3:0]  FlagsE;
    logic        stall_o, BranchTakenE, FlagUpdE;
    logic [3:0]  FlagsNextE;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  WA3M;
    logic        RegWriteM, MemtoRegM, MemWriteM;

    vec_exec_stage dut (
        .clk(clk), .reset(reset), .clr(clr),
        .rdo1(rdo1), .rdo2(rdo2), .exto(exto), .ao3(ao3),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .PCSrcE(PCSrcE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE), .FlagsE(FlagsE),
        .stall_o(stall_o), .BranchTakenE(BranchTakenE), .FlagsNextE(FlagsNextE), .FlagUpdE(FlagUpdE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int stall_seen = 0;

    // Model state: whether a MUL is in flight and how many steps it has done
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_a = '0, m_b = '0;

    // Expected values consumed by the compare process
    bit          chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_br = 1'b0, exp_upd = 1'b0;
    logic [3:0]  exp_flags = '0;
    logic [31:0] exp_res = '0, exp_wd = '0;
    logic [2:0]  exp_wa = '0;
    logic        exp_rw = 1'b0, exp_m2r = 1'b0, exp_mw = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Lane arithmetic straight from the op definitions, using plain integers
    function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output logic c, output logic v);
        logic [31:0] res;
        res = '0;
        c = 1'b0;
        v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int ua, ub, sa, sb, r, sr;
            ua = int'(a[8*i +: 8]);
            ub = int'(b[8*i +: 8]);
            sa = (ua > 127) ? ua - 256 : ua;
            sb = (ub > 127) ? ub - 256 : ub;
            sr = 0;
            case (op)
                3'd0: begin r = ua + ub; sr = sa + sb; if (r > 255) c = 1'b1; end
                3'd1: begin r = ua - ub; sr = sa - sb; if (ua >= ub) c = 1'b1; end
                3'd2: r = ua & ub;
                3'd3: r = ua | ub;
                3'd4: r = ua * ub;
                3'd5: r = ua << (ub % 8);
                3'd6: r = ua >> (ub % 8);
                default: r = ub;
            endcase
            if (sr > 127 || sr < -128) v = 1'b1;
            res[8*i +: 8] = r[7:0];
        end
        return res;
    endfunction

    // Compare process: combinational outputs and E/M register every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_o === 1'b1) stall_seen++;
            chk("stall_o", 32'(stall_o), 32'(exp_stall));
            chk("BranchTakenE", 32'(BranchTakenE), 32'(exp_br));
            chk("FlagUpdE", 32'(FlagUpdE), 32'(exp_upd));
            if (exp_upd) chk("FlagsNextE", 32'(FlagsNextE), 32'(exp_flags));
            chk("ALUResultM", ALUResultM, exp_res);
            chk("WriteDataM", WriteDataM, exp_wd);
            chk("WA3M", 32'(WA3M), 32'(exp_wa));
            chk("RegWriteM", 32'(RegWriteM), 32'(exp_rw));
            chk("MemtoRegM", 32'(MemtoRegM), 32'(exp_m2r));
            chk("MemWriteM", 32'(MemWriteM), 32'(exp_mw));
        end
    end

    // One clock of stimulus: derive expectations from current inputs, cross the edge, advance model
    task automatic step();
        logic [31:0] sb, r;
        logic        c, v, cond, ld;
        logic [3:0]  fc;
        sb   = ALUSrcE ? exto : rdo2;
        cond = !CondE || FlagsE[2];
        ld   = 1'b0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        exp_br = (BranchE | PCSrcE) & cond & !m_busy;
        if (clr) begin
            exp_stall = 1'b0;
        end else if (m_busy) begin
            exp_stall = (m_cnt != 7);
            if (m_cnt == 7) begin
                r  = model_op(3'd4, m_a, m_b, c, v);
                ld = 1'b1;
            end
        end else if (ALUControlE == 3'd4) begin
            exp_stall = cond;
        end else begin
            exp_stall = 1'b0;
            r  = model_op(ALUControlE, rdo1, sb, c, v);
            ld = 1'b1;
        end
        fc    = FlagsE;
        fc[3] = r[31];
        fc[2] = (r == 32'd0);
        if (!m_busy && !clr && (ALUControlE == 3'd0 || ALUControlE == 3'd1)) begin
            fc[1] = c;
            fc[0] = v;
        end
        exp_flags = FlagsE;
        if (FlagWriteE[1]) exp_flags[3:2] = fc[3:2];
        if (FlagWriteE[0]) exp_flags[1:0] = fc[1:0];
        exp_upd = cond & (|FlagWriteE) & !exp_stall;
        chk_en  = 1'b1;
        @(posedge clk);
        if (clr) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 7) m_busy = 1'b0;
            else            m_cnt++;
        end else if (ALUControlE == 3'd4 && cond) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_a    = rdo1;
            m_b    = sb;
        end
        if (ld && !clr) begin
            exp_res = r;        exp_wd = rdo2;    exp_wa = ao3;
            exp_rw  = RegWriteE & cond; exp_m2r = MemtoRegE; exp_mw = MemWriteE & cond;
        end else begin
            exp_res = '0; exp_wd = '0; exp_wa = '0;
            exp_rw  = 1'b0; exp_m2r = 1'b0; exp_mw = 1'b0;
        end
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic alusrc, input logic [1:0] fw,
                          input logic conde, input logic [3:0] flags, input logic rw,
                          input logic mw, input logic [2:0] wa);
        ALUControlE = op;  rdo1 = a;  rdo2 = b;  exto = imm;  ALUSrcE = alusrc;
        FlagWriteE  = fw;  CondE = conde;  FlagsE = flags;
        RegWriteE   = rw;  MemWriteE = mw;  MemtoRegE = mw;  ao3 = wa;
        BranchE     = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic set_nop();
        set_op(3'd0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    endtask

    // Issue a MUL already on the inputs; stop when the model reaches stop_at or the MUL retires
    task automatic run_mul(input int stop_at);
        step();
        for (int k = 0; k < 16 && m_busy && (m_cnt != stop_at); k++) step();
    endtask

    localparam logic [2:0]  T_OP [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd4, 3'd0, 3'd1};
    localparam logic [31:0] T_A  [8] = '{32'h05030080, 32'hF0F0FF00, 32'h12003400, 32'h01010101,
                                         32'h00000000, 32'h03020110, 32'h7F7F7F7F, 32'h12345678};
    localparam logic [31:0] T_B  [8] = '{32'h03050001, 32'h0FF0F0F0, 32'h00560078, 32'h11111111,
                                         32'h22222222, 32'h05040302, 32'h01010101, 32'h12345678};
    localparam logic [31:0] T_I  [8] = '{32'h0, 32'h0, 32'h0, 32'h00010207,
                                         32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    localparam logic        T_S  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [1:0]  T_FW [8] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    localparam logic        T_CE [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [3:0]  T_FL [8] = '{4'b0000, 4'b0011, 4'b1100, 4'b0101,
                                         4'b0000, 4'b0000, 4'b0100, 4'b1000};
    localparam logic        T_MW [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        set_nop();
        #12;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ALUResultM", ALUResultM, 32'd0);
        chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
        chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        step();

        // ADD: lane 2 carries, lane 1 overflows; bit 31 of 0x02008020 is clear so N=0
        set_op(3'd0, 32'h01FF7F10, 32'h01010110, '0, 1'b0, 2'b11, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd2);
        #1;
        chk("add_flags_lit", 32'(FlagsNextE), 32'(4'b0011));
        chk("add_upd_lit", 32'(FlagUpdE), 32'd1);
        step();
        chk("add_res_lit", ALUResultM, 32'h02008020);
        set_nop();
        step();

        // MUL: eight stall cycles, product after the ninth
        set_op(3'd4, 32'h03020110, 32'h05040302, '0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd3);
        stall_seen = 0;
        run_mul(-1);
        chk("mul_stall_cycles", 32'(stall_seen), 32'd8);
        chk("mul_res_lit", ALUResultM, 32'h0F080320);
        set_nop();
        step();

        // Condition fails: no write, no flag update, no branch
        set_op(3'd0, 32'h11111111, 32'h22222222, '0, 1'b0, 2'b11, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd4);
        BranchE = 1'b1;
        #1;
        chk("cond_branch_lit", 32'(BranchTakenE), 32'd0);
        chk("cond_upd_lit", 32'(FlagUpdE), 32'd0);
        step();
        chk("cond_regwrite_lit", 32'(RegWriteM), 32'd0);
        set_nop();
        BranchE = 1'b1;
        step();
        BranchE = 1'b0;

        // Flush a MUL at cnt=3, then a plain ADD retires in one cycle
        set_op(3'd4, 32'h03020110, 32'h05040302, '0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd3);
        run_mul(3);
        clr = 1'b1;
        #1 chk("clr_stall_lit", 32'(stall_o), 32'd0);
        step();
        clr = 1'b0;
        set_op(3'd0, 32'h01020304, 32'h10203040, '0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd1);
        step();
        chk("post_clr_add_lit", ALUResultM, 32'h11223344);
        set_nop();
        step();

        // Reset mid-MUL at cnt=5, then a clean restart
        set_op(3'd4, 32'h03020110, 32'h05040302, '0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd3);
        run_mul(5);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rstmid_stall", 32'(stall_o), 32'd0);
        chk("rstmid_ALUResultM", ALUResultM, 32'd0);
        chk("rstmid_RegWriteM", 32'(RegWriteM), 32'd0);
        chk("rstmid_WA3M", 32'(WA3M), 32'd0);
        m_busy  = 1'b0;
        exp_res = '0; exp_wd = '0; exp_wa = '0;
        exp_rw  = 1'b0; exp_m2r = 1'b0; exp_mw = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        stall_seen = 0;
        run_mul(-1);
        chk("restart_stall_cycles", 32'(stall_seen), 32'd8);
        chk("restart_res_lit", ALUResultM, 32'h0F080320);

        // SHR with immediate operand
        set_op(3'd6, 32'h80402010, '0, 32'h01020304, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd7);
        step();
        chk("shr_res_lit", ALUResultM, 32'h40100401);

        // Mixed directed vectors checked against the model
        for (int i = 0; i < 8; i++) begin
            set_op(T_OP[i], T_A[i], T_B[i], T_I[i], T_S[i], T_FW[i], T_CE[i], T_FL[i],
                   1'b1, T_MW[i], 3'(i));
            step();
            for (int k = 0; k < 16 && m_busy; k++) step();
        end
        set_nop();
        step();
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
